serial_word_transmitter: RTL and testbench
==========================================

Name: serial_word_transmitter

Overview:
- Parallel-in, serial-out transmitter. It is the unloading counterpart of the enable-loaded word register used in the accumulator datapath.
- It captures one Word_Length word on a start/ready handshake and shifts it out on a single line as a framed stream: start bit, data LSB-first, optional parity, stop bit.
- It sits between the accumulator output register and an off-block serial link.

Parameters:
- Word_Length, 8, data word width in bits (>=1).
- Clks_Per_Bit, 4, clk cycles each serial bit is held on tx (>=1).
- Parity_Enable, 1, 1 inserts a parity bit after the data bits; 0 omits it.
- Parity_Odd, 0, 0 selects even parity, 1 selects odd. Ignored when Parity_Enable=0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to transmit Data_Input; sampled only when ready=1.
- Data_Input  input  Word_Length  word to send; captured on the accepting edge.
- ready  output  1  high when idle and able to accept start.
- busy  output  1  high while a frame is in progress (always the complement of ready).
- tx  output  1  serial line; idles high.
- done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset values: tx=1, ready=1, busy=0, done=0, state=IDLE, all counters 0. Reset acts asynchronously, including mid-frame: tx returns to 1 immediately, the frame is aborted, and no done is produced.
- All outputs are registered or decoded from registered state only, with no combinational path from start or Data_Input.
- States are IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, ready=1. On a rising edge with start=1, Data_Input is captured into a shift register and the state moves to START.
  - START: tx=0 for Clks_Per_Bit cycles, then DATA.
  - DATA: tx = shift_reg[0]. After each Clks_Per_Bit cycles, shift right by one and increment the bit counter. After Word_Length bits, go to PARITY if Parity_Enable=1, else STOP.
  - PARITY: tx = XOR of the captured word, XOR Parity_Odd. Held for Clks_Per_Bit cycles, then STOP.
  - STOP: tx=1 for Clks_Per_Bit cycles, then IDLE with done=1 for exactly that first IDLE cycle.
- Frame length:
  - N = 1 + Word_Length + Parity_Enable + 1 bits.
  - tx is low from the acceptance edge onward.
  - done is high in the cycle beginning N*Clks_Per_Bit cycles after the acceptance edge.
- Counters:
  - Divider counter width is clog2(Clks_Per_Bit)+1 and wraps from Clks_Per_Bit-1 to 0.
  - Bit counter width is clog2(Word_Length)+1.
  - Neither counter wraps mid-bit.
- Data_Input changes after acceptance do not affect the frame in flight.
- start while busy=1 is ignored and is not queued.
- start during the done cycle (already IDLE, ready=1) is accepted. The minimum gap between frames is therefore exactly one idle-high cycle (the done cycle).
- start held continuously high sends back-to-back frames, re-sampling Data_Input at each acceptance.
- Clks_Per_Bit=1 is legal: each bit lasts one cycle.

Test Plan:
1. Assert reset low for 3 cycles, then release with start=0 -> tx=1, ready=1, busy=0, done=0. Hold for 10 cycles -> no change.
2. Defaults, start=1 for one cycle with Data_Input=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles; parity bit = 0. busy=1 for 44 cycles; done=1 exactly 44 cycles after the acceptance edge.
3. During the frame from scenario 2, pulse start with Data_Input=8'hFF at cycle 10 -> ignored. Frame bits unchanged; exactly one done; no second frame follows.
4. Hold start=1 with Data_Input=8'h01, switching to 8'h80 after acceptance -> first frame sends 8'h01. Second frame is accepted in the done cycle with exactly one tx=1 idle cycle between the stop bit and the next start bit, and sends 8'h80 with parity 1.
5. Send 8'h3C and assert reset low mid-frame during data bit 3 -> tx=1 and busy=0 asynchronously, and no done. After release, start with 8'h5A -> a clean full frame.
6. Data_Input=8'h07:
   - Parity_Odd=0 -> parity bit 1.
   - Parity_Odd=1 -> parity bit 0.
   - Parity_Enable=0 -> frame is 10 bits and done occurs at 40 cycles.

Source files
------------

// File: rtl/serial_word_transmitter.sv
// Parallel-in, serial-out framed transmitter: start bit, LSB-first data,
// optional parity, stop bit. One word is captured per start/ready handshake.
module serial_word_transmitter #(
  parameter int Word_Length   = 8,
  parameter int Clks_Per_Bit  = 4,
  parameter bit Parity_Enable = 1'b1,
  parameter bit Parity_Odd    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [Word_Length-1:0] Data_Input,
  output logic                   ready,
  output logic                   busy,
  output logic                   tx,
  output logic                   done
);

  localparam int DIV_W = $clog2(Clks_Per_Bit) + 1;
  localparam int BIT_W = $clog2(Word_Length) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(Clks_Per_Bit - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(Word_Length - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 r_state;
  logic [DIV_W-1:0]       r_div;
  logic [BIT_W-1:0]       r_bit;
  logic [Word_Length-1:0] r_shift;
  logic                   r_par;
  logic                   r_tx;
  logic                   r_ready;
  logic                   r_done;

  logic [Word_Length-1:0] w_shift_next;
  logic                   w_bit_end;

  assign w_shift_next = r_shift >> 1;
  assign w_bit_end    = (r_div == DIV_LAST);

  // tx is registered one bit ahead: each transition loads the level of the
  // bit being entered, so the line changes exactly on the bit boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE) begin
        r_div <= w_bit_end ? '0 : r_div + 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= Data_Input;
            r_par   <= (^Data_Input) ^ Parity_Odd;
            r_div   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_ready <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit == BIT_LAST) begin
              r_bit <= '0;
              if (Parity_Enable) begin
                r_tx    <= r_par;
                r_state <= PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              r_shift <= w_shift_next;
              r_tx    <= w_shift_next[0];
              r_bit   <= r_bit + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx    = r_tx;
  assign ready = r_ready;
  assign busy  = ~r_ready;
  assign done  = r_done;

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Bench for serial_word_transmitter: table-driven frames through a scoreboard
// monitor, plus hand-written back-to-back, abort and parameter-variant cases.
module tb_serial_word_transmitter;

  localparam int CPB    = 4;
  localparam int NBITS  = 11;
  localparam int FR_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       start_aux = 1'b0;
  logic [7:0] Data_Input = 8'h00;

  logic ready, busy, tx, done;
  logic ready_odd, busy_odd, tx_odd, done_odd;
  logic ready_nop, busy_nop, tx_nop, done_nop;
  logic ready_fast, busy_fast, tx_fast, done_fast;

  always #5 clk = ~clk;

  serial_word_transmitter u_dut (
    .clk(clk), .reset(reset), .start(start), .Data_Input(Data_Input),
    .ready(ready), .busy(busy), .tx(tx), .done(done)
  );

  serial_word_transmitter #(.Parity_Odd(1'b1)) u_odd (
    .clk(clk), .reset(reset), .start(start_aux), .Data_Input(Data_Input),
    .ready(ready_odd), .busy(busy_odd), .tx(tx_odd), .done(done_odd)
  );

  serial_word_transmitter #(.Parity_Enable(1'b0)) u_nop (
    .clk(clk), .reset(reset), .start(start_aux), .Data_Input(Data_Input),
    .ready(ready_nop), .busy(busy_nop), .tx(tx_nop), .done(done_nop)
  );

  serial_word_transmitter #(.Clks_Per_Bit(1)) u_fast (
    .clk(clk), .reset(reset), .start(start_aux), .Data_Input(Data_Input),
    .ready(ready_fast), .busy(busy_fast), .tx(tx_fast), .done(done_fast)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  logic [NBITS-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [NBITS-1:0] frame(input logic [7:0] d, input logic par);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    start = 1'b1;
    Data_Input = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    i = 0;
    while (done !== 1'b1 && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (done !== 1'b1) check(name, 32'd0, 32'd1);
  endtask

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) n_done++;
  end

  // Frame monitor: samples mid-bit, checks busy/done timing, pops expected frame.
  bit               m_in = 1'b0;
  bit               m_busy_bad;
  int               m_cnt;
  logic [NBITS-1:0] m_bits;
  logic [NBITS-1:0] m_exp;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      m_in = 1'b0;
    end else begin
      if (!m_in && tx === 1'b0) begin
        m_in = 1'b1;
        m_cnt = 0;
        m_bits = '0;
        m_busy_bad = 1'b0;
      end
      if (m_in) begin
        if (m_cnt < FR_CYC) begin
          if (m_cnt % CPB == CPB / 2) m_bits[m_cnt / CPB] = tx;
          if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) m_busy_bad = 1'b1;
        end else begin
          check("busy_during_frame", {31'd0, m_busy_bad}, 32'd0);
          check("done_at_N_bits", {29'd0, done, busy, tx}, 32'b101);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            m_exp = exp_q.pop_front();
            check("frame_bits", {21'd0, m_bits}, {21'd0, m_exp});
          end
          m_in = 1'b0;
        end
        m_cnt++;
      end
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int d0;
    bit bad;
    logic [NBITS-1:0] fast_bits;
    logic odd_par, nop_d7, nop_stop, nop_done_early, nop_done, fast_done_early, fast_done, odd_done;
    logic [5:0] aux_idle;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h6E, 1'b1};
    vecs[4] = '{8'h10, 1'b1};
    vecs[5] = '{8'hC3, 1'b0};
    vecs[6] = '{8'h07, 1'b1};

    // Reset and idle hold
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, tx, ready, busy, done}, 32'b1100);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {28'd0, tx, ready, busy, done}, 32'b1100);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if ({tx, ready, busy, done} !== 4'b1100) bad = 1'b1;
    end
    check("idle_hold", {31'd0, bad}, 32'd0);

    // Table-driven frames
    foreach (vecs[i]) begin
      exp_q.push_back(frame(vecs[i].data, vecs[i].par));
      send(vecs[i].data);
      wait_done("table_done_timeout", FR_CYC + 10);
      repeat (2) @(negedge clk);
    end
    check("table_queue_drained", exp_q.size(), 32'd0);

    // start while busy is ignored
    d0 = n_done;
    exp_q.push_back(frame(8'hA5, 1'b0));
    send(8'hA5);
    repeat (9) @(negedge clk);
    start = 1'b1;
    Data_Input = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start_done_timeout", FR_CYC + 10);
    repeat (60) @(negedge clk);
    check("busy_start_one_done", n_done - d0, 32'd1);
    check("busy_start_queue", exp_q.size(), 32'd0);

    // Back-to-back frames with start held high
    exp_q.push_back(frame(8'h01, 1'b1));
    exp_q.push_back(frame(8'h80, 1'b1));
    @(negedge clk);
    start = 1'b1;
    Data_Input = 8'h01;
    @(negedge clk);
    Data_Input = 8'h80;
    wait_done("b2b_done1_timeout", FR_CYC + 10);
    @(negedge clk);
    start = 1'b0;
    check("b2b_single_idle_gap", {30'd0, tx, busy}, 32'b01);
    wait_done("b2b_done2_timeout", FR_CYC + 10);
    repeat (3) @(negedge clk);
    check("b2b_queue", exp_q.size(), 32'd0);

    // Asynchronous reset mid-frame (data bit 3)
    d0 = n_done;
    exp_q.push_back(frame(8'h3C, 1'b0));
    send(8'h3C);
    repeat (17) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_async_outputs", {28'd0, tx, ready, busy, done}, 32'b1100);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", n_done - d0, 32'd0);
    exp_q.push_back(frame(8'h5A, 1'b0));
    send(8'h5A);
    wait_done("after_abort_done_timeout", FR_CYC + 10);
    repeat (2) @(negedge clk);
    check("after_abort_queue", exp_q.size(), 32'd0);

    // Parameter variants: odd parity, no parity, one clock per bit
    fast_bits = '0;
    @(negedge clk);
    start_aux = 1'b1;
    Data_Input = 8'h07;
    @(negedge clk);
    start_aux = 1'b0;
    for (int c = 0; c <= FR_CYC; c++) begin
      if (c <= 10) fast_bits[c] = tx_fast;
      if (c == 10) fast_done_early = done_fast;
      if (c == 11) fast_done = done_fast;
      if (c == 34) nop_d7 = tx_nop;
      if (c == 38) begin
        odd_par  = tx_odd;
        nop_stop = tx_nop;
      end
      if (c == 39) nop_done_early = done_nop;
      if (c == 40) nop_done = done_nop;
      if (c == FR_CYC) begin
        odd_done = done_odd;
        aux_idle = {ready_odd, ready_nop, ready_fast, busy_odd, busy_nop, busy_fast};
      end
      if (c < FR_CYC) @(negedge clk);
    end
    check("odd_parity_bit", {31'd0, odd_par}, 32'd0);
    check("odd_done_at_44", {31'd0, odd_done}, 32'd1);
    check("nopar_last_data_then_stop", {30'd0, nop_d7, nop_stop}, 32'b01);
    check("nopar_done_at_40", {30'd0, nop_done_early, nop_done}, 32'b01);
    check("cpb1_frame", {21'd0, fast_bits}, 32'h60E);
    check("cpb1_done_at_11", {30'd0, fast_done_early, fast_done}, 32'b01);
    check("aux_idle_after", {26'd0, aux_idle}, 32'b111000);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
